// File: rtl/spi_slave_resp.sv
// spi_slave_resp: oversampled SPI responder (CPHA=0) with one-entry TX and RX holding registers.
// Optional `SPI_SLV_ECHO_EN: an empty TX holding register sends the last completed RX byte.
module spi_slave_resp_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ff <= {STAGES{RST_VAL}};
    else         ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module spi_slave_resp #(
  parameter bit         CPOL        = 1'b0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_clk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       rx_overrun_o
);
  localparam int NUM_LANES = 3;
  // Lane order: 0 = spi_clk, 1 = spi_ss, 2 = spi_mosi; reset to their idle levels.
  localparam logic [NUM_LANES-1:0] SYNC_RST = {1'b0, 1'b1, CPOL};

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [NUM_LANES-1:0] pin_raw, pin_s;
  logic       clk_s, ss_s, mosi_s, clk_q, ss_q;
  logic       lead, trail, ss_fall, ss_rise;
  state_t     state, state_nxt;
  logic [7:0] tx_hold, tx_shift, rx_shift, rx_byte, empty_byte, load_byte;
  logic       tx_full, skip_shift, byte_done, load_pt;
  logic [2:0] bitcnt;

  assign pin_raw = {spi_mosi_i, spi_ss_i, spi_clk_i};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_sync
    spi_slave_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[g])) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d      (pin_raw[g]),
      .q      (pin_s[g])
    );
  end

  assign {mosi_s, ss_s, clk_s} = pin_s;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      clk_q <= CPOL;
      ss_q  <= 1'b1;
    end else begin
      clk_q <= clk_s;
      ss_q  <= ss_s;
    end

  assign lead    = (clk_s != CPOL) && (clk_q == CPOL);
  assign trail   = (clk_s == CPOL) && (clk_q != CPOL);
  assign ss_fall = ss_q && !ss_s;
  assign ss_rise = !ss_q && ss_s;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state == ACTIVE);
    spi_miso_oe_o = (state == ACTIVE);
    spi_miso_o    = (state == ACTIVE) && tx_shift[7];
  end

  assign byte_done = (state == ACTIVE) && !ss_rise && lead && (bitcnt == 3'd7);
  assign load_pt   = ((state == IDLE) && ss_fall) || byte_done;
  assign rx_byte   = {rx_shift[6:0], mosi_s};

`ifdef SPI_SLV_ECHO_EN
  logic [7:0] echo_byte;
  logic       echo_vld;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      echo_byte <= '0;
      echo_vld  <= 1'b0;
    end else if (byte_done) begin
      echo_byte <= rx_byte;
      echo_vld  <= 1'b1;
    end

  // At a byte boundary the byte completing this cycle is the most recent one.
  assign empty_byte = (state == ACTIVE) ? rx_byte : (echo_vld ? echo_byte : FILL_BYTE);
`else
  assign empty_byte = FILL_BYTE;
`endif

  assign load_byte  = tx_full ? tx_hold : empty_byte;
  assign tx_ready_o = !tx_full;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tx_full <= 1'b0;
      tx_hold <= '0;
    end else begin
      if (load_pt) tx_full <= 1'b0;
      if (tx_valid_i && tx_ready_o) begin
        tx_full <= 1'b1;
        tx_hold <= tx_data_i;
      end
    end

  // The trailing edge right after a reload is swallowed so the new MSB stays on MISO.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      bitcnt     <= '0;
      skip_shift <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ss_fall) begin
          tx_shift   <= load_byte;
          rx_shift   <= '0;
          bitcnt     <= '0;
          skip_shift <= 1'b0;
        end
        ACTIVE: if (ss_rise) begin
          tx_shift   <= '0;
          rx_shift   <= '0;
          bitcnt     <= '0;
          skip_shift <= 1'b0;
        end else if (lead) begin
          rx_shift <= rx_byte;
          bitcnt   <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            tx_shift   <= load_byte;
            skip_shift <= 1'b1;
          end
        end else if (trail) begin
          if (skip_shift) skip_shift <= 1'b0;
          else            tx_shift   <= {tx_shift[6:0], 1'b0};
        end
        default: ;
      endcase
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      rx_overrun_o <= 1'b0;
      if (byte_done) begin
        if (rx_valid_o && !rx_ready_i) begin
          rx_overrun_o <= 1'b1;
        end else begin
          rx_data_o  <= rx_byte;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_slave_resp.sv
// Bench for spi_slave_resp: a CPOL=0 and a CPOL=1 instance driven by a bit-banged SPI master.
module tb_spi_slave_resp;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;

  logic       sclk0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b0, miso0, oe0;
  logic [7:0] txd0 = '0, rxd0;
  logic       txv0 = 1'b0, txr0, rxv0, rxr0 = 1'b0, busy0, ovr0;

  logic       sclk1 = 1'b1, ss1 = 1'b1, mosi1 = 1'b0, miso1, oe1;
  logic [7:0] txd1 = '0, rxd1;
  logic       txv1 = 1'b0, txr1, rxv1, rxr1 = 1'b0, busy1, ovr1;

  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0;

  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (ovr0) ovr_cnt <= ovr_cnt + 1;

  spi_slave_resp #(.CPOL(1'b0)) u0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .spi_clk_i(sclk0), .spi_ss_i(ss0), .spi_mosi_i(mosi0),
    .spi_miso_o(miso0), .spi_miso_oe_o(oe0), .tx_data_i(txd0), .tx_valid_i(txv0),
    .tx_ready_o(txr0), .rx_data_o(rxd0), .rx_valid_o(rxv0), .rx_ready_i(rxr0),
    .busy_o(busy0), .rx_overrun_o(ovr0)
  );

  spi_slave_resp #(.CPOL(1'b1)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .spi_clk_i(sclk1), .spi_ss_i(ss1), .spi_mosi_i(mosi1),
    .spi_miso_o(miso1), .spi_miso_oe_o(oe1), .tx_data_i(txd1), .tx_valid_i(txv1),
    .tx_ready_o(txr1), .rx_data_o(rxd1), .rx_valid_o(rxv1), .rx_ready_i(rxr1),
    .busy_o(busy1), .rx_overrun_o(ovr1)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Master side, CPHA=0: data set up half a period ahead, MISO captured at the leading edge.
  task automatic spi_xfer(input bit cp, input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (cp) mosi1 = mo[i]; else mosi0 = mo[i];
      step(5);
      mi[i] = cp ? miso1 : miso0;
      if (cp) sclk1 = 1'b0; else sclk0 = 1'b1;
      step(5);
      if (cp) sclk1 = 1'b1; else sclk0 = 1'b0;
    end
  endtask

  task automatic tx_push(input bit cp, input logic [7:0] b);
    if (cp) begin txd1 = b; txv1 = 1'b1; end else begin txd0 = b; txv0 = 1'b1; end
    step(1);
    txv0 = 1'b0; txv1 = 1'b0;
  endtask

  task automatic rx_accept(input bit cp);
    if (cp) rxr1 = 1'b1; else rxr0 = 1'b1;
    step(1);
    rxr0 = 1'b0; rxr1 = 1'b0;
  endtask

  task automatic test_reset;
    step(1);
    total++; if (txr0 !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", txr0); end
    total++; if (rxv0 !== 1'b0 || rxd0 !== 8'h00) begin bad++; $display("FAIL reset_rx got=%b/%h want=0/00", rxv0, rxd0); end
    total++; if ({miso0, oe0, busy0, ovr0} !== 4'b0) begin bad++; $display("FAIL reset_outs got=%b want=0000", {miso0, oe0, busy0, ovr0}); end
    rst_ni = 1'b1;
    step(4);
    for (int k = 0; k < 8; k++) begin
      sclk0 = ~sclk0;
      step(5);
      total++;
      if ({busy0, oe0, rxv0, miso0} !== 4'b0) begin
        bad++; $display("FAIL idle_toggle got=%b want=0000", {busy0, oe0, rxv0, miso0});
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] mi, e;
    tx_push(0, 8'hA5);
    total++; if (txr0 !== 1'b0) begin bad++; $display("FAIL tx_full_ready got=%b want=0", txr0); end
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    ss0 = 1'b0;
    step(8);
    total++; if ({busy0, oe0, txr0} !== 3'b111) begin bad++; $display("FAIL frame_start got=%b want=111", {busy0, oe0, txr0}); end
    spi_xfer(0, 8'h3C, 8, mi);
    step(2);
    e = exp_miso_q.pop_front();
    total++; if (mi !== e) begin bad++; $display("FAIL basic_miso got=%h want=%h", mi, e); end
    e = exp_rx_q.pop_front();
    total++; if (rxv0 !== 1'b1 || rxd0 !== e) begin bad++; $display("FAIL basic_rx got=%b/%h want=1/%h", rxv0, rxd0, e); end
    ss0 = 1'b1;
    step(8);
    total++; if ({busy0, oe0, miso0} !== 3'b000) begin bad++; $display("FAIL frame_end got=%b want=000", {busy0, oe0, miso0}); end
    total++; if (rxv0 !== 1'b1 || rxd0 !== e) begin bad++; $display("FAIL rx_hold got=%b/%h want=1/%h", rxv0, rxd0, e); end
    rx_accept(0);
    total++; if (rxv0 !== 1'b0) begin bad++; $display("FAIL rx_accept got=%b want=0", rxv0); end
  endtask

  task automatic test_multi;
    logic [7:0] mi, e;
    logic [7:0] mo [3];
    mo = '{8'h01, 8'h02, 8'h03};
    tx_push(0, 8'h11);
    exp_miso_q.push_back(8'h11);
`ifdef SPI_SLV_ECHO_EN
    exp_miso_q.push_back(8'h01);
    exp_miso_q.push_back(8'h02);
`else
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
`endif
    ss0 = 1'b0;
    step(8);
    for (int b = 0; b < 3; b++) begin
      exp_rx_q.push_back(mo[b]);
      spi_xfer(0, mo[b], 8, mi);
      step(2);
      e = exp_miso_q.pop_front();
      total++; if (mi !== e) begin bad++; $display("FAIL multi_miso[%0d] got=%h want=%h", b, mi, e); end
      e = exp_rx_q.pop_front();
      total++; if (rxv0 !== 1'b1 || rxd0 !== e) begin bad++; $display("FAIL multi_rx[%0d] got=%b/%h want=1/%h", b, rxv0, rxd0, e); end
      rx_accept(0);
    end
    ss0 = 1'b1;
    step(8);
  endtask

  task automatic test_overrun;
    logic [7:0] mi, e;
    int ovr_base;
    ovr_base = ovr_cnt;
`ifdef SPI_SLV_ECHO_EN
    exp_miso_q.push_back(8'h03);
    exp_miso_q.push_back(8'h55);
`else
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
`endif
    exp_rx_q.push_back(8'h55);
    ss0 = 1'b0;
    step(8);
    spi_xfer(0, 8'h55, 8, mi);
    e = exp_miso_q.pop_front();
    total++; if (mi !== e) begin bad++; $display("FAIL ovr_miso0 got=%h want=%h", mi, e); end
    spi_xfer(0, 8'hAA, 8, mi);
    e = exp_miso_q.pop_front();
    total++; if (mi !== e) begin bad++; $display("FAIL ovr_miso1 got=%h want=%h", mi, e); end
    ss0 = 1'b1;
    step(8);
    e = exp_rx_q.pop_front();
    total++; if (rxv0 !== 1'b1 || rxd0 !== e) begin bad++; $display("FAIL ovr_rx got=%b/%h want=1/%h", rxv0, rxd0, e); end
    total++; if (ovr_cnt - ovr_base !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ovr_cnt - ovr_base); end
    rx_accept(0);
    total++; if (rxv0 !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b want=0", rxv0); end
  endtask

  task automatic test_abort;
    logic [7:0] mi, e;
    ss0 = 1'b0;
    step(8);
    tx_push(0, 8'h5A);
    spi_xfer(0, 8'hF8, 5, mi);
    ss0 = 1'b1;
    step(8);
    total++; if ({rxv0, oe0, busy0, miso0} !== 4'b0) begin bad++; $display("FAIL abort_outs got=%b want=0000", {rxv0, oe0, busy0, miso0}); end
    total++; if (txr0 !== 1'b0) begin bad++; $display("FAIL abort_hold got=%b want=0", txr0); end
    exp_miso_q.push_back(8'h5A);
    exp_rx_q.push_back(8'h7E);
    ss0 = 1'b0;
    step(8);
    spi_xfer(0, 8'h7E, 8, mi);
    step(2);
    e = exp_miso_q.pop_front();
    total++; if (mi !== e) begin bad++; $display("FAIL abort_miso got=%h want=%h", mi, e); end
    e = exp_rx_q.pop_front();
    total++; if (rxv0 !== 1'b1 || rxd0 !== e) begin bad++; $display("FAIL abort_rx got=%b/%h want=1/%h", rxv0, rxd0, e); end
    rx_accept(0);
    ss0 = 1'b1;
    step(8);
  endtask

  task automatic test_cpol1;
    logic [7:0] mi, e;
    total++; if ({oe1, busy1, rxv1} !== 3'b000) begin bad++; $display("FAIL cpol1_idle got=%b want=000", {oe1, busy1, rxv1}); end
    tx_push(1, 8'hC3);
    exp_miso_q.push_back(8'hC3);
    exp_rx_q.push_back(8'h96);
    ss1 = 1'b0;
    step(8);
    spi_xfer(1, 8'h96, 8, mi);
    step(2);
    e = exp_miso_q.pop_front();
    total++; if (mi !== e) begin bad++; $display("FAIL cpol1_miso got=%h want=%h", mi, e); end
    e = exp_rx_q.pop_front();
    total++; if (rxv1 !== 1'b1 || rxd1 !== e) begin bad++; $display("FAIL cpol1_rx got=%b/%h want=1/%h", rxv1, rxd1, e); end
    ss1 = 1'b1;
    step(8);
    total++; if ({oe1, busy1} !== 2'b00) begin bad++; $display("FAIL cpol1_end got=%b want=00", {oe1, busy1}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_multi;
    test_overrun;
    test_abort;
    test_cpol1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
